// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: channel FSM encodings
// and the default stability window.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } btn_state_e;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_if.sv
// Button bundle between the board pins and the debouncer: raw pins in,
// clean levels out.
interface debounce_if #(
  parameter int NUM_BTN = 5
);
  logic [NUM_BTN-1:0] pb_raw;
  logic [NUM_BTN-1:0] pb_debounced;

  modport master (output pb_raw, input  pb_debounced);
  modport slave  (input  pb_raw, output pb_debounced);
endinterface

// File: rtl/debounce_channel.sv
// One button: 2-FF synchroniser followed by a stability-count FSM; the
// output level only moves after STABLE_CYCLES consecutive opposite samples.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic pb_debounced
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_q, s2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             out_q, out_d;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      ST_LOW: if (s2_q) begin
        if (STABLE_CYCLES == 1) begin
          state_d = ST_HIGH;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = ST_RISE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RISE_WAIT: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = ST_HIGH;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_HIGH: if (!s2_q) begin
        if (STABLE_CYCLES == 1) begin
          state_d = ST_LOW;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = ST_FALL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FALL_WAIT: begin
        // a single high sample cancels the release attempt
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = ST_LOW;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      s1_q    <= pb_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign pb_debounced = out_q;

endmodule

// File: rtl/debounce.sv
// Debouncer for the board push-buttons: NUM_BTN independent channels, each
// feeding one downstream edge-to-pulse stage.
module debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN       = 5,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  debounce_if.slave  bus
);

  if (STABLE_CYCLES < 1 || NUM_BTN < 1) begin : g_bad_cfg
    $error("debounce: STABLE_CYCLES and NUM_BTN must both be >= 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pb_raw       (bus.pb_raw[i]),
      .pb_debounced (bus.pb_debounced[i])
    );
  end

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: directed scenarios plus a random soak, all checked
// against a sliding-window model of the debounce rule.
module tb_debounce;
  localparam int NB = 2;
  localparam int SC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  debounce_if #(.NUM_BTN(NB)) bus ();

  debounce #(.NUM_BTN(NB), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: raw goes through two sample delays; output flips once the last SC
  // samples seen since the previous flip all disagree with the output.
  logic [NB-1:0] m_s1, m_s2, m_out;
  bit            hist [NB][$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_out = '0;
    for (int c = 0; c < NB; c++) hist[c].delete();
  endtask

  task automatic step(input logic [NB-1:0] raw);
    logic [NB-1:0] fin;
    bit            all_opp;
    bus.pb_raw = raw;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      fin  = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int c = 0; c < NB; c++) begin
        hist[c].push_back(fin[c]);
        if (hist[c].size() > SC) void'(hist[c].pop_front());
        if (hist[c].size() == SC) begin
          all_opp = 1'b1;
          for (int k = 0; k < SC; k++) if (hist[c][k] == m_out[c]) all_opp = 1'b0;
          if (all_opp) begin
            m_out[c] = ~m_out[c];
            hist[c].delete();
          end
        end
      end
    end
    #1;
  endtask

  // Hold reset for two edges, release between edges; next step is edge 0.
  task automatic do_reset(input logic [NB-1:0] raw);
    rst_n = 1'b0;
    model_reset();
    #1;
    repeat (2) step(raw);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.pb_raw = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pb_debounced !== 2'b00) begin
      errors++; $display("FAIL reset_async_t0 got=%b want=00", bus.pb_debounced);
    end
    model_reset();
    repeat (2) step(2'b11);
    rst_n = 1'b1;
    for (int e = 0; e < 6; e++) step(2'b11);
    checks++;
    if (bus.pb_debounced !== 2'b11 || m_out !== 2'b11) begin
      errors++; $display("FAIL held_at_release got=%b model=%b want=11", bus.pb_debounced, m_out);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.pb_debounced !== 2'b00) begin
      errors++; $display("FAIL reset_async_high got=%b want=00", bus.pb_debounced);
    end
  endtask

  task automatic test_clean_press();
    do_reset(2'b00);
    for (int e = 0; e <= 5; e++) begin
      step(2'b01);
      checks++;
      if (bus.pb_debounced[0] !== (e >= 5) || m_out[0] !== (e >= 5)) begin
        errors++; $display("FAIL press_edge%0d got=%b model=%b want=%b", e, bus.pb_debounced[0], m_out[0], e >= 5);
      end
    end
    for (int e = 0; e <= 5; e++) begin
      step(2'b00);
      checks++;
      if (bus.pb_debounced[0] !== (e < 5)) begin
        errors++; $display("FAIL release_edge%0d got=%b want=%b", e, bus.pb_debounced[0], e < 5);
      end
    end
  endtask

  task automatic test_bounce();
    logic [NB-1:0] pat;
    do_reset(2'b00);
    for (int e = 0; e <= 9; e++) begin
      pat = (e == 3) ? 2'b00 : 2'b01;
      step(pat);
      checks++;
      if (bus.pb_debounced[0] !== (e >= 9) || m_out[0] !== (e >= 9)) begin
        errors++; $display("FAIL bounce_edge%0d got=%b model=%b want=%b", e, bus.pb_debounced[0], m_out[0], e >= 9);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic [NB-1:0] pat;
    do_reset(2'b00);
    repeat (6) step(2'b01);
    for (int e = 0; e < 10; e++) begin
      pat = (e < 2) ? 2'b00 : 2'b01;
      step(pat);
      checks++;
      if (bus.pb_debounced[0] !== 1'b1) begin
        errors++; $display("FAIL release_glitch_edge%0d got=%b want=1", e, bus.pb_debounced[0]);
      end
    end
  endtask

  task automatic test_independence();
    logic [NB-1:0] pat, want;
    do_reset(2'b00);
    for (int e = 0; e <= 8; e++) begin
      pat  = (e < 2) ? 2'b01 : 2'b11;
      step(pat);
      want = {1'(e >= 7), 1'(e >= 5)};
      checks++;
      if (bus.pb_debounced !== want || m_out !== want) begin
        errors++; $display("FAIL indep_edge%0d got=%b model=%b want=%b", e, bus.pb_debounced, m_out, want);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(2'b00);
    repeat (3) step(2'b01);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.pb_debounced !== 2'b00) begin
      errors++; $display("FAIL midwait_async got=%b want=00", bus.pb_debounced);
    end
    repeat (2) step(2'b01);
    rst_n = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step(2'b01);
      checks++;
      if (bus.pb_debounced[0] !== (e >= 5)) begin
        errors++; $display("FAIL midwait_edge%0d got=%b want=%b", e, bus.pb_debounced[0], e >= 5);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] raw;
    raw = '0;
    do_reset(raw);
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(5) == 0) raw[c] = ~raw[c];
      step(raw);
      checks++;
      if (bus.pb_debounced !== m_out) begin
        errors++; $display("FAIL random_cyc%0d got=%b model=%b raw=%b", n, bus.pb_debounced, m_out, raw);
      end
    end
  endtask

  initial begin
    bus.pb_raw = '0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_independence();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
